// File: rtl/id_ex_pipe_reg_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_pipe_reg_pkg
// Types and constants shared between the decoder and the pipeline registers
// around the ID/EX boundary.
//   ctrl_t     : decoder control bundle {ALUOp[1:0], ALUSrc, RegWrite,
//                MemRead, MemWrite, MemtoReg}, 7 bits
//   CTRL_ZERO  : the all-inactive bundle loaded on a bubble
//   OP_*       : RV32I major opcodes recognised by the decoder
// ----------------------------------------------------------------------------
package id_ex_pipe_reg_pkg;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_ZERO = '0;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BEQ    = 7'b1100011;

endpackage : id_ex_pipe_reg_pkg

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Unsigned up-counter that saturates at all-ones instead of wrapping.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low clear
//   i_inc    : count one event this cycle
//   i_hold   : freeze the count (wins over i_inc)
//   o_cnt    : current count
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_hold,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = &r_cnt;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_hold && i_inc && !w_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule : sat_counter

// File: rtl/id_ex_pipe_reg.sv
// ----------------------------------------------------------------------------
// id_ex_pipe_reg
// ID -> EX pipeline register. Captures the decoder control bundle and the
// ID-stage operands each cycle, with stall (hold) and flush (bubble) control,
// and counts bubbles that enter EX.
//   clk_i, rst_i         : clock (rising edge), async active-low reset
//   Stall_i, Flush_i     : hold all fields / load a bubble (flush wins)
//   Valid_i              : ID instruction is real (0 = fetch bubble)
//   ALUOp_i..MemtoReg_i  : decoder control bundle
//   PC_i, RS1data_i, RS2data_i, Imm_i, Funct_i, RS1addr_i, RS2addr_i,
//   RDaddr_i             : ID-stage operands
//   *_o                  : registered twins of every *_i above
//   BubbleCnt_o          : saturating count of bubbles loaded into EX
// ----------------------------------------------------------------------------
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              Stall_i,
  input  logic              Flush_i,
  input  logic              Valid_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              MemtoReg_i,
  input  logic [DATA_W-1:0] PC_i,
  input  logic [DATA_W-1:0] RS1data_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic [9:0]        Funct_i,
  input  logic [REG_AW-1:0] RS1addr_i,
  input  logic [REG_AW-1:0] RS2addr_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  output logic              Valid_o,
  output logic [1:0]        ALUOp_o,
  output logic              ALUSrc_o,
  output logic              RegWrite_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              MemtoReg_o,
  output logic [DATA_W-1:0] PC_o,
  output logic [DATA_W-1:0] RS1data_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [DATA_W-1:0] Imm_o,
  output logic [9:0]        Funct_o,
  output logic [REG_AW-1:0] RS1addr_o,
  output logic [REG_AW-1:0] RS2addr_o,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic [CNT_W-1:0]  BubbleCnt_o
);

  ctrl_t             w_ctrl_in;
  ctrl_t             r_ctrl;
  logic              r_valid;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
  logic [DATA_W-1:0] r_imm;
  logic [9:0]        r_funct;
  logic [REG_AW-1:0] r_rs1_addr;
  logic [REG_AW-1:0] r_rs2_addr;
  logic [REG_AW-1:0] r_rd_addr;

  logic              w_hold;
  logic              w_bubble;
  logic [CNT_W-1:0]  w_bubble_cnt;

  assign w_ctrl_in = '{alu_op:     ALUOp_i,
                       alu_src:    ALUSrc_i,
                       reg_write:  RegWrite_i,
                       mem_read:   MemRead_i,
                       mem_write:  MemWrite_i,
                       mem_to_reg: MemtoReg_i};

  // Flush overrides stall, so a stall only holds when no flush is pending.
  assign w_hold   = Stall_i & ~Flush_i;
  // A bubble enters EX on a flush, or on a normal load of an invalid slot.
  assign w_bubble = Flush_i | (~Stall_i & ~Valid_i);

  // NOTE: the operand registers are reset along with the control bits; zeroed
  // RDaddr after reset keeps the forwarding unit from matching on stale data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid    <= 1'b0;
      r_ctrl     <= CTRL_ZERO;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_funct    <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
    end else if (Flush_i) begin
      r_valid    <= 1'b0;
      r_ctrl     <= CTRL_ZERO;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_funct    <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
    end else if (!Stall_i) begin
      r_valid    <= Valid_i;
      r_ctrl     <= w_ctrl_in;
      r_pc       <= PC_i;
      r_rs1_data <= RS1data_i;
      r_rs2_data <= RS2data_i;
      r_imm      <= Imm_i;
      r_funct    <= Funct_i;
      r_rs1_addr <= RS1addr_i;
      r_rs2_addr <= RS2addr_i;
      r_rd_addr  <= RDaddr_i;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_inc   (w_bubble),
    .i_hold  (w_hold),
    .o_cnt   (w_bubble_cnt)
  );

  assign Valid_o     = r_valid;
  assign ALUOp_o     = r_ctrl.alu_op;
  assign ALUSrc_o    = r_ctrl.alu_src;
  assign RegWrite_o  = r_ctrl.reg_write;
  assign MemRead_o   = r_ctrl.mem_read;
  assign MemWrite_o  = r_ctrl.mem_write;
  assign MemtoReg_o  = r_ctrl.mem_to_reg;
  assign PC_o        = r_pc;
  assign RS1data_o   = r_rs1_data;
  assign RS2data_o   = r_rs2_data;
  assign Imm_o       = r_imm;
  assign Funct_o     = r_funct;
  assign RS1addr_o   = r_rs1_addr;
  assign RS2addr_o   = r_rs2_addr;
  assign RDaddr_o    = r_rd_addr;
  assign BubbleCnt_o = w_bubble_cnt;

endmodule : id_ex_pipe_reg

// File: tb/tb_id_ex_pipe_reg.sv
// ----------------------------------------------------------------------------
// tb_id_ex_pipe_reg
// Two instances share one stimulus stream: dut_a with default widths and
// dut_s with a 3-bit bubble counter so saturation is reachable. Every clock
// edge the reference model's expected outputs are queued; a monitor pops
// and compares them away from the edge.
// ----------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [9:0]  funct;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rda;
  } bundle_t;

  typedef struct packed {
    bundle_t     b;
    logic [31:0] cnt_a;
    logic [2:0]  cnt_s;
  } exp_t;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    stall;
  logic    flush;
  bundle_t vin;

  always #5 clk = ~clk;

  // dut_a outputs
  logic        a_valid, a_alu_src, a_reg_write, a_mem_read, a_mem_write, a_mem_to_reg;
  logic [1:0]  a_alu_op;
  logic [31:0] a_pc, a_rs1d, a_rs2d, a_imm, a_cnt;
  logic [9:0]  a_funct;
  logic [4:0]  a_rs1a, a_rs2a, a_rda;
  // dut_s outputs
  logic        s_valid, s_alu_src, s_reg_write, s_mem_read, s_mem_write, s_mem_to_reg;
  logic [1:0]  s_alu_op;
  logic [31:0] s_pc, s_rs1d, s_rs2d, s_imm;
  logic [2:0]  s_cnt;
  logic [9:0]  s_funct;
  logic [4:0]  s_rs1a, s_rs2a, s_rda;

  bundle_t out_a, out_s;
  assign out_a = {a_valid, a_alu_op, a_alu_src, a_reg_write, a_mem_read, a_mem_write,
                  a_mem_to_reg, a_pc, a_rs1d, a_rs2d, a_imm, a_funct, a_rs1a, a_rs2a, a_rda};
  assign out_s = {s_valid, s_alu_op, s_alu_src, s_reg_write, s_mem_read, s_mem_write,
                  s_mem_to_reg, s_pc, s_rs1d, s_rs2d, s_imm, s_funct, s_rs1a, s_rs2a, s_rda};

  id_ex_pipe_reg dut_a (
    .clk_i(clk), .rst_i(rst_n), .Stall_i(stall), .Flush_i(flush),
    .Valid_i(vin.valid), .ALUOp_i(vin.alu_op), .ALUSrc_i(vin.alu_src),
    .RegWrite_i(vin.reg_write), .MemRead_i(vin.mem_read), .MemWrite_i(vin.mem_write),
    .MemtoReg_i(vin.mem_to_reg), .PC_i(vin.pc), .RS1data_i(vin.rs1d), .RS2data_i(vin.rs2d),
    .Imm_i(vin.imm), .Funct_i(vin.funct), .RS1addr_i(vin.rs1a), .RS2addr_i(vin.rs2a),
    .RDaddr_i(vin.rda),
    .Valid_o(a_valid), .ALUOp_o(a_alu_op), .ALUSrc_o(a_alu_src), .RegWrite_o(a_reg_write),
    .MemRead_o(a_mem_read), .MemWrite_o(a_mem_write), .MemtoReg_o(a_mem_to_reg),
    .PC_o(a_pc), .RS1data_o(a_rs1d), .RS2data_o(a_rs2d), .Imm_o(a_imm), .Funct_o(a_funct),
    .RS1addr_o(a_rs1a), .RS2addr_o(a_rs2a), .RDaddr_o(a_rda), .BubbleCnt_o(a_cnt)
  );

  id_ex_pipe_reg #(.CNT_W(3)) dut_s (
    .clk_i(clk), .rst_i(rst_n), .Stall_i(stall), .Flush_i(flush),
    .Valid_i(vin.valid), .ALUOp_i(vin.alu_op), .ALUSrc_i(vin.alu_src),
    .RegWrite_i(vin.reg_write), .MemRead_i(vin.mem_read), .MemWrite_i(vin.mem_write),
    .MemtoReg_i(vin.mem_to_reg), .PC_i(vin.pc), .RS1data_i(vin.rs1d), .RS2data_i(vin.rs2d),
    .Imm_i(vin.imm), .Funct_i(vin.funct), .RS1addr_i(vin.rs1a), .RS2addr_i(vin.rs2a),
    .RDaddr_i(vin.rda),
    .Valid_o(s_valid), .ALUOp_o(s_alu_op), .ALUSrc_o(s_alu_src), .RegWrite_o(s_reg_write),
    .MemRead_o(s_mem_read), .MemWrite_o(s_mem_write), .MemtoReg_o(s_mem_to_reg),
    .PC_o(s_pc), .RS1data_o(s_rs1d), .RS2data_o(s_rs2d), .Imm_o(s_imm), .Funct_o(s_funct),
    .RS1addr_o(s_rs1a), .RS2addr_o(s_rs2a), .RDaddr_o(s_rda), .BubbleCnt_o(s_cnt)
  );

  int tests  = 0;
  int errors = 0;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the stage content as seen by EX plus an unbounded
  // bubble tally; the DUT counters are the tally clamped to their widths.
  bundle_t         m_state;
  longint unsigned m_bubbles;
  exp_t            sb[$];

  function automatic exp_t expected();
    exp_t e;
    e.b     = m_state;
    e.cnt_a = (m_bubbles > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_bubbles[31:0];
    e.cnt_s = (m_bubbles > 7) ? 3'd7 : m_bubbles[2:0];
    return e;
  endfunction

  function automatic bundle_t rand_bundle(input logic v);
    bundle_t b;
    b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b.valid = v;
    return b;
  endfunction

  // Apply one cycle of stimulus, let the edge happen, queue the expectation.
  task automatic step(input bundle_t v, input logic st, input logic fl);
    @(negedge clk);
    vin   = v;
    stall = st;
    flush = fl;
    @(posedge clk);
    if (fl) begin
      m_state = '0;
      m_bubbles++;
    end else if (!st) begin
      m_state = v;
      if (!v.valid) m_bubbles++;
    end
    sb.push_back(expected());
  endtask

  // Monitor: compare once outputs have settled after each edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("bundle_a", out_a, e.b);
      check("bubble_cnt_a", a_cnt, e.cnt_a);
      check("bundle_s", out_s, e.b);
      check("bubble_cnt_s", s_cnt, e.cnt_s);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bundle_t b;
    m_state   = '0;
    m_bubbles = 0;
    stall     = 1'b0;
    flush     = 1'b0;
    vin       = rand_bundle(1'b1);
    vin.rda   = 5'd9;
    rst_n     = 1'b0;

    // Reset from time zero, before any clock edge.
    #3;
    check("reset_bundle", out_a, 0);
    check("reset_cnt", a_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release loads the inputs.
    b = rand_bundle(1'b1);
    step(b, 1'b0, 1'b0);

    // Normal load.
    b = '0;
    b.valid = 1'b1; b.alu_op = 2'b00; b.reg_write = 1'b1;
    b.rs1d = 32'h0000_0005; b.rda = 5'd3;
    step(b, 1'b0, 1'b0);

    // LW bundle then three stalled cycles with garbage inputs.
    b = rand_bundle(1'b1);
    b.alu_op = 2'b01; b.alu_src = 1'b1; b.mem_read = 1'b1; b.mem_write = 1'b0;
    b.mem_to_reg = 1'b1; b.reg_write = 1'b1;
    step(b, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(rand_bundle($urandom_range(0, 1)), 1'b1, 1'b0);

    // Reset mid-stall, asserted between edges: outputs clear without an edge.
    @(negedge clk);
    stall = 1'b1;
    vin   = rand_bundle(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_bundle", out_a, 0);
    check("async_reset_cnt_s", s_cnt, 0);
    @(posedge clk);
    #1;
    check("reset_held_bundle", out_s, 0);
    m_state   = '0;
    m_bubbles = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // SW bundle stored, then stall and flush together.
    b = rand_bundle(1'b1);
    b.alu_op = 2'b00; b.alu_src = 1'b1; b.mem_write = 1'b1; b.mem_read = 1'b0;
    b.reg_write = 1'b0; b.mem_to_reg = 1'b0;
    step(b, 1'b0, 1'b0);
    step(rand_bundle(1'b1), 1'b1, 1'b1);

    // Bubble counting: four invalid loads, two valid, one valid NoOp.
    for (int i = 0; i < 4; i++) step(rand_bundle(1'b0), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(rand_bundle(1'b1), 1'b0, 1'b0);
    b = rand_bundle(1'b1);
    b.alu_op = 2'b00; b.alu_src = 1'b0; b.reg_write = 1'b0;
    b.mem_read = 1'b0; b.mem_write = 1'b0; b.mem_to_reg = 1'b0;
    step(b, 1'b0, 1'b0);

    // Ten flushes push the 3-bit counter into saturation.
    for (int i = 0; i < 10; i++) step(rand_bundle($urandom_range(0, 1)), $urandom_range(0, 1), 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step(rand_bundle($urandom_range(0, 3) != 0),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule : tb_id_ex_pipe_reg

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Pipeline register between the ID stage (control decoder, register file, immediate generator) and the EX stage (ALU control, ALU, forwarding unit).
- Captures the decoder's control bundle and the ID-stage operands on each clock edge.
- Supports hold (stall) and bubble insertion (flush).
- Keeps a saturating count of bubbles that enter EX, for performance measurement.

Parameters:
- DATA_W, 32, width of PC, register operands and immediate
- REG_AW, 5, register address width
- CNT_W, 32, width of the bubble counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- Stall_i  in  1  hold all stored fields this cycle
- Flush_i  in  1  load a bubble this cycle
- Valid_i  in  1  ID instruction is real (0 = fetch bubble)
- ALUOp_i  in  2  from decoder
- ALUSrc_i  in  1  from decoder
- RegWrite_i  in  1  from decoder
- MemRead_i  in  1  from decoder
- MemWrite_i  in  1  from decoder
- MemtoReg_i  in  1  from decoder
- PC_i  in  DATA_W  PC of ID instruction
- RS1data_i  in  DATA_W  register file read port 1
- RS2data_i  in  DATA_W  register file read port 2
- Imm_i  in  DATA_W  sign-extended immediate
- Funct_i  in  10  {funct7, funct3} for ALU control
- RS1addr_i  in  REG_AW  source register 1 address
- RS2addr_i  in  REG_AW  source register 2 address
- RDaddr_i  in  REG_AW  destination register address
- Each *_i above except clk_i, rst_i, Stall_i, Flush_i has a registered *_o twin with the same width.
- BubbleCnt_o  out  CNT_W  bubbles loaded into EX since reset

Behaviour:
- Reset (rst_i=0, asynchronous):
  - every *_o and BubbleCnt_o go to 0 immediately, independent of clk_i
  - stay 0 while rst_i=0
  - release is synchronous-safe: the first capture happens on the first rising edge with rst_i=1
- Priority at each rising edge: reset > Flush_i > Stall_i > normal load.
- Normal load (Flush_i=0, Stall_i=0): all *_o take their *_i values. Latency is one cycle.
- Flush (Flush_i=1, regardless of Stall_i):
  - all *_o load 0, including RDaddr_o=0, so the forwarding unit never matches x0
  - Valid_o=0
  - BubbleCnt_o increments
- Stall (Stall_i=1, Flush_i=0): all *_o and BubbleCnt_o hold their values.
- Bubble accounting:
  - on a normal load with Valid_i=0, the inputs are captured as-is and BubbleCnt_o increments
  - on a normal load with Valid_i=1, BubbleCnt_o is unchanged
  - a decoder NoOp (all controls 0 but Valid_i=1) is not counted; the hazard unit must drive Valid_i=0 alongside NoOp for it to be counted
- Counter:
  - unsigned, saturates at 2^CNT_W-1
  - no wrap to 0
  - holds while stalled
- No combinational path from any input to any output.
- Flush and stall asserted in the same cycle resolve as flush: the held instruction is discarded.
- Reset asserted mid-stall clears everything. There is no recovery of held state after reset.

Decomposition:
- Shared package:
  - the control-bundle typedef {ALUOp[1:0], ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg}, 7 bits
  - the zero-bundle constant
  - the opcode localparams already used by the decoder (R_TYPE 0110011, I_TYPE 0010011, LW 0000011, SW 0100011, BEQ 1100011)
- One natural sub-module: sat_counter (parameter W; inputs inc, hold; async active-low clear), reusable by later IF/ID and EX/MEM registers.

Test Plan:
- Reset: drive all inputs nonzero, pull rst_i low between edges -> all outputs 0 with no clock edge; after release, the first edge loads the inputs.
- Normal load: ALUOp_i=2'b00, RegWrite_i=1, RS1data_i=32'h0000_0005, RDaddr_i=5'd3, Valid_i=1 -> identical values on outputs one cycle later; BubbleCnt_o stays 0.
- Stall: load a LW bundle (ALUOp=01, ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1), then Stall_i=1 for 3 cycles while the inputs change to garbage -> outputs hold the LW bundle for all 3 cycles; counter unchanged.
- Flush with stall: Stall_i=1 and Flush_i=1 together with a SW bundle stored -> next cycle all outputs 0 (RDaddr_o=0, MemWrite_o=0, Valid_o=0); BubbleCnt_o +1.
- Bubble counting: 4 consecutive loads with Valid_i=0 then 2 with Valid_i=1 -> BubbleCnt_o=4; a NoOp load with Valid_i=1 leaves it at 4.
- Saturation: CNT_W=3, 10 flushes -> BubbleCnt_o reaches 7 and stays 7.
